counter2_ctrl: RTL and testbench

- Control stage directly upstream of the 8-bit loadable counter with carry-in/carry-out.
- Generates its `data`, `load` and `cin` inputs and consumes its `cout`.
- Accepts a reload value and prescale divider over a valid/ready config handshake, then paces counting with a programmable prescaler.
- Reports terminal count with a `done` pulse; either stops (one-shot) or reloads seamlessly (auto-reload).

---
 rtl/counter2_ctrl.sv | 147 ++++++++++++++
 tb/tb_counter2_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter2_ctrl.sv
// counter2_ctrl: config handshake, prescaler and run control for an 8-bit loadable counter.
// Optional auto-reload path is compiled in when COUNTER2_CTRL_AUTORELOAD_EN is defined.
module counter2_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_auto,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             cin,
    input  logic             cout,
    output logic             done,
    output logic             running
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] r_p;
    logic [DIV_W-1:0] w_p_nxt;
    logic [DIV_W-1:0] r_div;
    logic [WIDTH-1:0] r_data;
    logic             r_done;
    logic             w_accept;
    logic             w_tick;
    logic             w_term;
    logic             w_auto;

    assign w_accept = (r_state == S_IDLE) && cfg_valid;
    // stop suppresses a tick that lands in the same cycle
    assign w_tick   = (r_state == S_RUN) && (r_p == r_div);
    assign w_term   = cin && cout;

`ifdef COUNTER2_CTRL_AUTORELOAD_EN
    logic r_auto;

    // Auto-reload mode flag, captured with each accepted config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto <= 1'b0;
        end else if (w_accept) begin
            r_auto <= cfg_auto;
        end else begin
            r_auto <= r_auto;
        end
    end

    assign w_auto = r_auto;
    // Reload at terminal count replaces the wrap; the counter's load does not feed cout.
    assign load   = (r_state == S_LOAD) || (w_term && r_auto);
`else
    logic w_cfg_auto_unused;

    assign w_cfg_auto_unused = cfg_auto;
    assign w_auto            = 1'b0;
    assign load              = (r_state == S_LOAD);
`endif

    assign cfg_ready = (r_state == S_IDLE);
    assign cin       = w_tick && !stop;
    assign running   = (r_state == S_RUN);
    assign data      = r_data;
    assign done      = r_done;

    // Next-state and prescaler update.
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = {DIV_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_ARMED;
                end else if (w_term && !w_auto) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
                if (stop || w_tick) begin
                    w_p_nxt = {DIV_W{1'b0}};
                end else begin
                    w_p_nxt = r_p + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_p_nxt     = {DIV_W{1'b0}};
            end
        endcase
    end

    // State, prescaler and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= {DIV_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_done  <= w_term;
        end
    end

    // Reload value and divider, captured on the config handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= {WIDTH{1'b0}};
            r_div  <= {DIV_W{1'b0}};
        end else if (w_accept) begin
            r_data <= cfg_data;
            r_div  <= cfg_div;
        end else begin
            r_data <= r_data;
            r_div  <= r_div;
        end
    end

endmodule

// File: tb/tb_counter2_ctrl.sv
// Bench for counter2_ctrl driving a behavioural 8-bit loadable counter with carry-in/carry-out.
module tb_counter2_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic [7:0] cfg_div;
    logic       cfg_auto;
    logic       start;
    logic       stop;
    logic [7:0] data;
    logic       load;
    logic       cin;
    logic       cout;
    logic       done;
    logic       running;

    logic       cnt_clr;
    logic [7:0] cnt;

    int n_checks = 0;
    int n_errors = 0;

    counter2_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_div(cfg_div), .cfg_auto(cfg_auto),
        .start(start), .stop(stop),
        .data(data), .load(load), .cin(cin), .cout(cout),
        .done(done), .running(running)
    );

    always #5 clk = ~clk;

    // Downstream counter; has its own clear so the controller reset leaves it alone.
    always_ff @(posedge clk or posedge cnt_clr) begin
        if (cnt_clr) cnt <= 8'h00;
        else if (load) cnt <= data;
        else cnt <= cnt + {7'd0, cin};
    end
    assign cout = (cnt == 8'hFF) && cin;

    typedef struct packed {
        logic       vld;
        logic [7:0] cd;
        logic [7:0] cdv;
        logic       ca;
        logic       st;
        logic       sp;
        logic [21:0] e;
    } vec_t;

    vec_t vt [19];

    function automatic logic [21:0] ex(input logic rdy, input logic ld, input logic ci,
                                       input logic co, input logic dn, input logic rn,
                                       input logic [7:0] d, input logic [7:0] c);
        return {rdy, ld, ci, co, dn, rn, d, c};
    endfunction

    function automatic logic [21:0] obs();
        return {cfg_ready, load, cin, cout, done, running, data, cnt};
    endfunction

    task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (rdy,load,cin,cout,done,run,data,cnt)",
                     name, act, exp_v);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Configure from IDLE and start; returns at the negedge of RUN cycle 0.
    task automatic cfg_start(input logic [7:0] d, input logic [7:0] dv, input logic a);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_data = d; cfg_div = dv; cfg_auto = a;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int first_tick;
        logic e_cin, e_co, e_dn;
        logic [7:0] e_cnt;

        rst = 1'b1; cnt_clr = 1'b1;
        cfg_valid = 1'b0; cfg_data = 8'h00; cfg_div = 8'h00; cfg_auto = 1'b0;
        start = 1'b0; stop = 1'b0;

        vt[0]  = '{1'b1, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b0, ex(1,0,0,0,0,0,8'h00,8'h00)};
        vt[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,1,0,0,0,0,8'hFD,8'h00)};
        vt[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, ex(0,0,0,0,0,0,8'hFD,8'hFD)};
        vt[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,1,0,0,1,8'hFD,8'hFD)};
        vt[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,1,0,0,1,8'hFD,8'hFE)};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,1,1,0,1,8'hFD,8'hFF)};
        vt[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(1,0,0,0,1,0,8'hFD,8'h00)};
        vt[7]  = '{1'b1, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0, ex(1,0,0,0,0,0,8'hFD,8'h00)};
        vt[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,1,0,0,0,0,8'h10,8'h00)};
        vt[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, ex(0,0,0,0,0,0,8'h10,8'h10)};
        vt[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,0,1,8'h10,8'h10)};
        vt[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ex(0,0,0,0,0,1,8'h10,8'h10)};
        vt[12] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, ex(0,0,0,0,0,0,8'h10,8'h10)};
        vt[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,0,1,8'h10,8'h10)};
        vt[14] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,1,0,0,1,8'h10,8'h10)};
        vt[15] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ex(0,0,0,0,0,1,8'h10,8'h11)};
        vt[16] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, ex(0,0,0,0,0,1,8'h10,8'h11)};
        vt[17] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, ex(0,0,0,0,0,0,8'h10,8'h11)};
        vt[18] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, ex(0,0,0,0,0,0,8'h10,8'h11)};

        @(negedge clk);
        @(negedge clk);
        #1 chk("reset_state", obs(), ex(1,0,0,0,0,0,8'h00,8'h00));
        @(negedge clk);
        rst = 1'b0; cnt_clr = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            cfg_valid = vt[i].vld; cfg_data = vt[i].cd; cfg_div = vt[i].cdv;
            cfg_auto = vt[i].ca; start = vt[i].st; stop = vt[i].sp;
            #1 chk($sformatf("vec%0d", i), obs(), vt[i].e);
        end
        start = 1'b0; stop = 1'b0;

        // Asynchronous reset landing on a tick cycle, div=3
        pulse_rst();
        cfg_start(8'h40, 8'h03, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("rst_pre_tick", obs(), ex(0,0,1,0,0,1,8'h40,8'h40));
        rst = 1'b1;
        #1 chk("rst_immediate", obs(), ex(1,0,0,0,0,0,8'h00,8'h40));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("rst_after_release", obs(), ex(1,0,0,0,0,0,8'h00,8'h40));

        // Config request held during a one-shot run
        cfg_start(8'hFE, 8'h00, 1'b0);
        cfg_valid = 1'b1; cfg_data = 8'h55; cfg_div = 8'h02;
        #1 chk("hold_run0", obs(), ex(0,0,1,0,0,1,8'hFE,8'hFE));
        @(negedge clk);
        #1 chk("hold_run1", obs(), ex(0,0,1,1,0,1,8'hFE,8'hFF));
        @(negedge clk);
        #1 chk("hold_done_idle", obs(), ex(1,0,0,0,1,0,8'hFE,8'h00));
        @(negedge clk);
        #1 chk("hold_accepted", obs(), ex(0,1,0,0,0,0,8'h55,8'h00));
        cfg_valid = 1'b0;
        @(negedge clk);
        #1 chk("hold_armed", obs(), ex(0,0,0,0,0,0,8'h55,8'h55));

        // Maximum divider: first tick in RUN cycle 255
        pulse_rst();
        cfg_start(8'h00, 8'hFF, 1'b0);
        first_tick = -1;
        for (int i = 0; i < 300; i++) begin
            #1 if (cin && first_tick < 0) first_tick = i;
            @(negedge clk);
        end
        chk_int("div_max_first_tick", first_tick, 255);
        #1 chk("div_max_count", obs(), ex(0,0,0,0,0,1,8'h00,8'h01));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Auto-reload request with div=2
        pulse_rst();
        cfg_start(8'hFE, 8'h02, 1'b1);
`ifdef COUNTER2_CTRL_AUTORELOAD_EN
        for (int i = 0; i < 24; i++) begin
            e_cnt = (((i / 3) % 2) == 0) ? 8'hFE : 8'hFF;
            e_cin = ((i % 3) == 2);
            e_co  = ((i % 6) == 5);
            e_dn  = (i >= 6) && ((i % 6) == 0);
            #1 chk($sformatf("auto_c%0d", i), obs(), ex(0, e_co, e_cin, e_co, e_dn, 1, 8'hFE, e_cnt));
            @(negedge clk);
        end
`else
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                e_cnt = (i < 3) ? 8'hFE : 8'hFF;
                e_cin = ((i % 3) == 2);
                e_co  = (i == 5);
                #1 chk($sformatf("oneshot_c%0d", i), obs(), ex(0, 0, e_cin, e_co, 0, 1, 8'hFE, e_cnt));
            end else begin
                #1 chk("oneshot_end", obs(), ex(1,0,0,0,1,0,8'hFE,8'h00));
            end
            @(negedge clk);
        end
        #1 chk("oneshot_single_done", obs(), ex(1,0,0,0,0,0,8'hFE,8'h00));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
